// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI frame receive stage:
// FSM state encoding, default frame geometry and pin idle levels.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FULL,
        OVR
    } state_t;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int FRAME_BITS = 1 + ADDR_W_DEF + DATA_W_DEF;

    localparam int RW_BIT   = FRAME_BITS - 1;
    localparam int ADDR_MSB = RW_BIT - 1;
    localparam int ADDR_LSB = DATA_W_DEF;
    localparam int DATA_MSB = DATA_W_DEF - 1;
    localparam int DATA_LSB = 0;

    // Idle pin levels loaded into the synchronisers at reset.
    localparam logic NCS_IDLE  = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic COPI_IDLE = 1'b0;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop pin synchroniser with a history flop for edge pulses.
// Ports: clk, rst_n, i_pin (async) -> o_level, o_rise, o_fall.
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_hist <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 MSB-first frame receiver: {rw, addr, data} word + valid/err pulses.
// Ports: clk, rst_n, SCLK/COPI/nCS pins -> frame_* fields, busy, err_count.
// Optional macro SPI_RX_ERR_CNT_EN enables the saturating error counter.
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              COPI,
    input  logic              nCS,
    output logic              frame_valid,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int FB    = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FB + 1);

    logic w_sclk_rise;
    logic w_unused_sclk_lvl;
    logic w_unused_sclk_fall;
    logic w_copi;
    logic w_unused_copi_rise;
    logic w_unused_copi_fall;
    logic w_ncs;
    logic w_ncs_rise;
    logic w_ncs_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (SCLK),
        .o_level (w_unused_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_unused_sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(COPI_IDLE)) u_copi (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (COPI),
        .o_level (w_copi),
        .o_rise  (w_unused_copi_rise),
        .o_fall  (w_unused_copi_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(NCS_IDLE)) u_ncs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (nCS),
        .o_level (w_ncs),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    state_t             r_state;
    logic [FB-1:0]      r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_valid;
    logic               r_err;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            // A fall outside IDLE can only come from a glitch; restart cleanly.
            if (w_ncs_fall) begin
                r_state <= SHIFT;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: ;
                    SHIFT: begin
                        // nCS rise wins over a coincident SCLK rise.
                        if (w_ncs_rise) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end else if (w_sclk_rise) begin
                            r_shift <= {r_shift[FB-2:0], w_copi};
                            r_cnt   <= r_cnt + CNT_W'(1);
                            if (r_cnt == CNT_W'(FB - 1))
                                r_state <= FULL;
                        end
                    end
                    FULL: begin
                        if (w_ncs_rise) begin
                            r_valid <= 1'b1;
                            r_rw    <= r_shift[FB-1];
                            r_addr  <= r_shift[FB-2 -: ADDR_W];
                            r_data  <= r_shift[DATA_W-1:0];
                            r_state <= IDLE;
                        end else if (w_sclk_rise) begin
                            r_state <= OVR;
                        end
                    end
                    OVR: begin
                        if (w_ncs_rise) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign frame_valid = r_valid;
    assign frame_err   = r_err;
    assign frame_rw    = r_rw;
    assign frame_addr  = r_addr;
    assign frame_data  = r_data;
    assign busy        = ~w_ncs;

`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if (r_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: vector table of frames, scoreboard queue of
// expected valid/err pulses, plus reset and error-saturation sequences.
module tb_spi_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SCLK;
    logic       COPI;
    logic       nCS;
    logic       frame_valid;
    logic       frame_rw;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;
    logic       busy;
    logic [7:0] err_count;

    spi_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SCLK        (SCLK),
        .COPI        (COPI),
        .nCS         (nCS),
        .frame_valid (frame_valid),
        .frame_rw    (frame_rw),
        .frame_addr  (frame_addr),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

`ifdef SPI_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] w;
        int          n;
        bit          ok;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
    } vec_t;

    typedef struct {
        bit         ok;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    logic       m_rw   = 1'b0;
    logic [6:0] m_addr = '0;
    logic [7:0] m_data = '0;
    int         m_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid && frame_err)
                chk("valid_and_err", 32'd1, 32'd0);
            if (frame_valid || frame_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {frame_valid, frame_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", frame_valid, e.ok);
                    if (e.ok) begin
                        m_rw   = e.rw;
                        m_addr = e.addr;
                        m_data = e.data;
                    end else if (CNT_EN && m_cnt < 255) begin
                        m_cnt++;
                    end
                    chk("rw", frame_rw, m_rw);
                    chk("addr", frame_addr, m_addr);
                    chk("data", frame_data, m_data);
                end
            end
        end
    end

    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            COPI = (i < 16) ? w[15-i] : 1'b0;
            clks(4);
            SCLK = 1'b1;
            clks(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        e.ok   = v.ok;
        e.rw   = v.rw;
        e.addr = v.addr;
        e.data = v.data;
        q.push_back(e);
        nCS = 1'b0;
        clks(4);
        chk("busy_open", busy, 1'b1);
        shift_bits(v.w, v.n);
        clks(4);
        nCS  = 1'b1;
        COPI = 1'b0;
        clks(10);
        for (int c = 0; c < 20 && q.size() != 0; c++)
            clks(1);
        chk("drain_timeout", q.size(), 32'd0);
        q.delete();
        chk("busy_closed", busy, 1'b0);
        chk("err_count", err_count, m_cnt);
    endtask

    vec_t tbl[8];
    vec_t v;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h80FF, 16, 1'b1, 1'b1, 7'h00, 8'hFF};
        tbl[1] = '{16'h045A, 16, 1'b1, 1'b0, 7'h04, 8'h5A};
        tbl[2] = '{16'hABCD, 10, 1'b0, 1'b0, 7'h00, 8'h00};
        tbl[3] = '{16'h1234, 17, 1'b0, 1'b0, 7'h00, 8'h00};
        tbl[4] = '{16'h81F0, 16, 1'b1, 1'b1, 7'h01, 8'hF0};
        tbl[5] = '{16'hFFFF, 15, 1'b0, 1'b0, 7'h00, 8'h00};
        tbl[6] = '{16'h0000,  0, 1'b0, 1'b0, 7'h00, 8'h00};
        tbl[7] = '{16'h7F01, 16, 1'b1, 1'b0, 7'h7F, 8'h01};

        rst_n = 1'b0;
        SCLK  = 1'b0;
        COPI  = 1'b0;
        nCS   = 1'b1;
        clks(3);
        chk("rst_valid", frame_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fields", {frame_rw, frame_addr, frame_data}, 16'h0);
        chk("rst_cnt", err_count, 8'h0);
        rst_n = 1'b1;
        clks(5);

        for (int i = 0; i < 8; i++)
            send(tbl[i]);

        // Reset in the middle of a frame; the master abandons it.
        nCS = 1'b0;
        clks(4);
        shift_bits(16'h8380, 8);
        rst_n = 1'b0;
        m_rw   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_cnt  = 0;
        clks(2);
        chk("mid_rst_valid", frame_valid, 1'b0);
        chk("mid_rst_err", frame_err, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_fields", {frame_rw, frame_addr, frame_data}, 16'h0);
        chk("mid_rst_cnt", err_count, 8'h0);
        nCS  = 1'b1;
        SCLK = 1'b0;
        COPI = 1'b0;
        clks(4);
        rst_n = 1'b1;
        clks(12);
        chk("post_rst_busy", busy, 1'b0);
        v = '{16'h8380, 16, 1'b1, 1'b1, 7'h03, 8'h80};
        send(v);

        for (int i = 0; i < 300; i++) begin
            v = '{16'h8000, 1, 1'b0, 1'b0, 7'h00, 8'h00};
            send(v);
        end
        chk("final_cnt", err_count, CNT_EN ? 32'd255 : 32'd0);
        chk("final_fields", {frame_rw, frame_addr, frame_data}, 16'h8380);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
